// File: rtl/encoder_a2_if.sv
// Serial message-in / codeword-out handshake bundle for encoder_a2.
// master = encoder side, slave = the source/sink environment around it.
interface encoder_a2_if;
    logic data_in;
    logic in_valid;
    logic in_flag;
    logic data_out;
    logic out_flag;
    logic out_ready;
    logic out_sof;

    modport master (
        input  data_in, in_valid, out_ready,
        output in_flag, data_out, out_flag, out_sof
    );

    modport slave (
        output data_in, in_valid, out_ready,
        input  in_flag, data_out, out_flag, out_sof
    );
endinterface

// File: rtl/encoder_a2.sv
// Serial systematic cyclic (K,K+P) encoder: K message bits MSB first, then P
// parity bits (remainder of x^P*m(x) mod g(x)), one bit per output handshake.
module encoder_a2 #(
    parameter int unsigned     K     = 4,
    parameter int unsigned     P     = 3,
    parameter logic [P-1:0]    GPOLY = 3'b011
) (
    input  logic            clk,
    input  logic            rst_n,   // active-high asynchronous reset
    encoder_a2_if.master    bus
);

    localparam int unsigned MAX_CNT = (K > P) ? K : P;
    localparam int unsigned CNT_W   = $clog2(MAX_CNT) + 1;

    typedef enum logic [0:0] {
        ST_MSG = 1'b0,
        ST_PAR = 1'b1
    } state_e;

    state_e             state_q,    state_d;
    logic [CNT_W-1:0]   bit_cnt_q,  bit_cnt_d;
    logic [P-1:0]       r_q,        r_d;
    logic               data_out_q, data_out_d;
    logic               out_flag_q, out_flag_d;
    logic               out_sof_q,  out_sof_d;

    logic               slot_free_c;
    logic               in_flag_c;
    logic               fb_c;

    // State register
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q    <= ST_MSG;
            bit_cnt_q  <= '0;
            r_q        <= '0;
            data_out_q <= 1'b0;
            out_flag_q <= 1'b0;
            out_sof_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            r_q        <= r_d;
            data_out_q <= data_out_d;
            out_flag_q <= out_flag_d;
            out_sof_q  <= out_sof_d;
        end
    end

    // Next-state: output slot refills only when empty or being drained
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        r_d         = r_q;
        data_out_d  = data_out_q;
        out_flag_d  = out_flag_q;
        out_sof_d   = out_sof_q;
        slot_free_c = !out_flag_q || bus.out_ready;
        in_flag_c   = !rst_n && slot_free_c && (state_q == ST_MSG);
        fb_c        = bus.data_in ^ r_q[P-1];

        unique case (state_q)
            ST_MSG: begin
                if (bus.in_valid && in_flag_c) begin
                    data_out_d = bus.data_in;
                    out_flag_d = 1'b1;
                    out_sof_d  = (bit_cnt_q == '0);
                    r_d        = {r_q[P-2:0], 1'b0} ^ (fb_c ? GPOLY : P'(0));
                    if (bit_cnt_q == CNT_W'(K - 1)) begin
                        bit_cnt_d = '0;
                        state_d   = ST_PAR;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end else if (slot_free_c) begin
                    out_flag_d = 1'b0;
                    out_sof_d  = 1'b0;
                end
            end
            ST_PAR: begin
                if (slot_free_c) begin
                    data_out_d = r_q[P-1];
                    r_d        = r_q << 1;
                    out_flag_d = 1'b1;
                    out_sof_d  = 1'b0;
                    if (bit_cnt_q == CNT_W'(P - 1)) begin
                        bit_cnt_d = '0;
                        r_d       = '0;
                        state_d   = ST_MSG;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = ST_MSG;
        endcase
    end

    assign bus.in_flag  = in_flag_c;
    assign bus.data_out = data_out_q;
    assign bus.out_flag = out_flag_q;
    assign bus.out_sof  = out_sof_q;

endmodule

// File: doc/encoder_a2.md
Name: encoder_a2

Overview:
- Serial systematic cyclic (7,4) encoder. It sits directly upstream of decoder_A2.
- Accepts message bits one per handshake, MSB first. Emits each 7-bit codeword serially: 4 message bits followed by 3 parity bits, computed with generator g(x)=x^3+x+1.
- The output interface connects bit-for-bit to the decoder's serial input: data_out to its data_in, out_ready from its in_flag.

Parameters:
- K, 4, message bits per codeword
- P, 3, parity bits per codeword (N=K+P)
- GPOLY, 3'b011, low-order coefficients g_{P-1}..g_0 of the generator; x^P term implied

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst_n  input  1  asynchronous reset, active-high (1 = reset asserted)
- data_in  input  1  current message bit from source
- in_valid  input  1  data_in holds a valid message bit
- in_flag  output  1  encoder can take a message bit this cycle
- data_out  output  1  current codeword bit
- out_flag  output  1  data_out valid
- out_ready  input  1  downstream can take data_out this cycle (driven by decoder in_flag)
- out_sof  output  1  high while data_out is the first bit of a codeword

Behaviour:
- Reset (asynchronous, any time, including mid-codeword):
  - state=MSG, bit_cnt=0, parity register r[P-1:0]=0.
  - data_out=0, out_flag=0, out_sof=0. in_flag follows combinationally: 1 while reset is deasserted, 0 while asserted.
  - A partially sent codeword is discarded; the next accepted bit starts a new codeword.
- Output slot: slot_free = !out_flag || out_ready. out_flag/data_out/out_sof hold steady while out_flag && !out_ready.
- State MSG:
  - in_flag = slot_free (combinational).
  - Accept event = in_valid && in_flag at a rising edge. On accept:
    - data_out<=data_in, out_flag<=1, out_sof<=(bit_cnt==0).
    - LFSR update: fb=data_in^r[P-1]; r<={r[P-2:0],1'b0} ^ (fb ? GPOLY : 0).
    - bit_cnt++.
  - On the K-th accept: bit_cnt<=0, state<=PAR.
  - If no accept but slot_free: out_flag<=0, out_sof<=0.
- State PAR:
  - in_flag=0; data_in is ignored.
  - Each edge with slot_free: data_out<=r[P-1], r<=r<<1, out_flag<=1, out_sof<=0, bit_cnt++.
  - On the P-th parity load: bit_cnt<=0, r<=0, state<=MSG.
- Latency and throughput:
  - An accepted bit appears on data_out the edge after it is accepted.
  - With out_ready tied 1 and in_valid always 1, output is gap-free: 7 valid bits per 7 cycles. in_flag is high 4 of every 7 cycles.
- Invariants:
  - No bit is lost or duplicated under any out_ready pattern.
  - Codeword boundaries are preserved across stalls.
  - in_valid may toggle freely; a gap in in_valid produces a gap in out_flag and never corrupts r.
- GPOLY=3'b011 yields parity = remainder of x^3*m(x) mod g(x), output r2 first.

Test Plan:
- Reset, then stream message 1000 with out_ready=1 -> out_flag bits 1000101, out_sof high only on first bit; in_flag low exactly 3 cycles.
- Stream 1101, 1111, 0000 back-to-back -> 1101001, 1111111, 0000000 with no out_flag gaps; the 21 bits are accepted cleanly by decoder_A2 with data_out matching messages.
- Message 1000 with out_ready low for 3 cycles during the 2nd message bit and 2 cycles during the 1st parity bit -> data_out/out_flag held during stalls; accepted sequence still 1000101; in_flag=0 while stalled.
- in_valid pulsed low between every message bit of 1101 -> out_flag gaps appear, accepted codeword still 1101001.
- Assert rst_n after 5 bits of a codeword, release, send 1000 -> outputs 0 immediately on assert; next codeword 1000101 with out_sof on its first bit.
- Random messages and random out_ready/in_valid for 10k codewords -> scoreboard vs. software (7,4) encoder, zero mismatches.
